row_accumulator: RTL and testbench

ROW_ACCUMULATOR -- requirements
Module: row_accumulator

---
 rtl/row_accumulator_if.sv | 28 ++
 rtl/row_accumulator.sv | 164 ++++++++++++++++
 tb/tb_row_accumulator.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_accumulator_if.sv
// Bundle of the per-lane product FIFO, row-length FIFO and sum handshake
// signals between the row accumulator and its surroundings.
interface row_accumulator_if #(
    parameter int channel_num = 4,
    parameter int val_bits    = 16,
    parameter int len_bits    = 16,
    parameter int acc_bits    = 40
);
    logic [channel_num*2*val_bits-1:0] mult;
    logic [channel_num-1:0]            mult_fifo_empty;
    logic [channel_num-1:0]            mult_fifo_read;
    logic [channel_num*len_bits-1:0]   rowlen;
    logic [channel_num-1:0]            rowlen_fifo_empty;
    logic [channel_num-1:0]            rowlen_fifo_read;
    logic [channel_num*acc_bits-1:0]   sum;
    logic [channel_num-1:0]            sum_valid;
    logic [channel_num-1:0]            sum_ready;

    modport master (
        output mult, mult_fifo_empty, rowlen, rowlen_fifo_empty, sum_ready,
        input  mult_fifo_read, rowlen_fifo_read, sum, sum_valid
    );

    modport slave (
        input  mult, mult_fifo_empty, rowlen, rowlen_fifo_empty, sum_ready,
        output mult_fifo_read, rowlen_fifo_read, sum, sum_valid
    );
endinterface

// File: rtl/row_accumulator.sv
// Per-lane sparse row accumulator: pops a row length, sums that many signed
// products, then presents the row sum until the consumer accepts it.

module row_accumulator_checker #(
    parameter int channel_num = 4
) (
    input logic                   clk,
    input logic                   rst,
    input logic [channel_num-1:0] mult_fifo_empty,
    input logic [channel_num-1:0] mult_fifo_read,
    input logic [channel_num-1:0] rowlen_fifo_empty,
    input logic [channel_num-1:0] rowlen_fifo_read
);
    localparam logic [channel_num-1:0] NONE = {channel_num{1'b0}};

    a_no_read_when_empty: assert property (@(posedge clk)
        ((mult_fifo_read & mult_fifo_empty) == NONE) &&
        ((rowlen_fifo_read & rowlen_fifo_empty) == NONE));

    a_no_read_in_reset: assert property (@(posedge clk)
        rst |-> ((mult_fifo_read == NONE) && (rowlen_fifo_read == NONE)));

    a_one_fifo_per_lane: assert property (@(posedge clk)
        (mult_fifo_read & rowlen_fifo_read) == NONE);
endmodule

module row_accumulator #(
    parameter int channel_num = 4,
    parameter int val_bits    = 16,
    parameter int len_bits    = 16,
    parameter int acc_bits    = 40
) (
    input logic               clk,
    input logic               rst,
    row_accumulator_if.slave  bus
);
    localparam int prod_bits = 2 * val_bits;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    for (genvar g = 0; g < channel_num; g++) begin : g_lane
        logic [1:0]                 state_q, state_d;
        logic signed [acc_bits-1:0] acc_q, acc_d;
        logic signed [acc_bits-1:0] sum_q, sum_d;
        logic [len_bits-1:0]        remaining_q, remaining_d;
        logic                       valid_q, valid_d;

        logic signed [prod_bits-1:0] prod_s;
        logic signed [acc_bits-1:0]  prod_ext_s;
        logic signed [acc_bits-1:0]  acc_plus_s;
        logic [len_bits-1:0]         rowlen_s;
        logic                        mult_empty_s, rowlen_empty_s, ready_s;
        logic                        mult_rd_s, rowlen_rd_s;

        assign prod_s         = bus.mult[g*prod_bits +: prod_bits];
        assign prod_ext_s     = acc_bits'(prod_s);
        assign acc_plus_s     = acc_q + prod_ext_s;
        assign rowlen_s       = bus.rowlen[g*len_bits +: len_bits];
        assign mult_empty_s   = bus.mult_fifo_empty[g];
        assign rowlen_empty_s = bus.rowlen_fifo_empty[g];
        assign ready_s        = bus.sum_ready[g];

        // Lane next-state logic; pops are gated by reset and by the empty flags.
        always_comb begin
            state_d     = state_q;
            acc_d       = acc_q;
            sum_d       = sum_q;
            remaining_d = remaining_q;
            valid_d     = valid_q;
            mult_rd_s   = 1'b0;
            rowlen_rd_s = 1'b0;
            if (!rst) begin
                case (state_q)
                    ST_IDLE: begin
                        rowlen_rd_s = ~rowlen_empty_s;
                        if (rowlen_rd_s) begin
                            remaining_d = rowlen_s;
                            acc_d       = {acc_bits{1'b0}};
                            if (rowlen_s != {len_bits{1'b0}}) begin
                                state_d = ST_ACC;
                            end else begin
                                state_d = ST_OUT;
                                sum_d   = {acc_bits{1'b0}};
                                valid_d = 1'b1;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_ACC: begin
                        mult_rd_s = ~mult_empty_s;
                        if (mult_rd_s) begin
                            acc_d       = acc_plus_s;
                            remaining_d = remaining_q - len_bits'(1);
                            if (remaining_q == len_bits'(1)) begin
                                // Last product goes straight into the result.
                                sum_d   = acc_plus_s;
                                valid_d = 1'b1;
                                state_d = ST_OUT;
                            end else begin
                                state_d = ST_ACC;
                            end
                        end else begin
                            state_d = ST_ACC;
                        end
                    end
                    ST_OUT: begin
                        valid_d = 1'b1;
                        if (ready_s) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                        end else begin
                            state_d = ST_OUT;
                        end
                    end
                    default: begin
                        state_d     = ST_IDLE;
                        acc_d       = {acc_bits{1'b0}};
                        remaining_d = {len_bits{1'b0}};
                        valid_d     = 1'b0;
                    end
                endcase
            end else begin
                mult_rd_s   = 1'b0;
                rowlen_rd_s = 1'b0;
            end
        end

        // Lane state registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= ST_IDLE;
                acc_q       <= {acc_bits{1'b0}};
                sum_q       <= {acc_bits{1'b0}};
                remaining_q <= {len_bits{1'b0}};
                valid_q     <= 1'b0;
            end else begin
                state_q     <= state_d;
                acc_q       <= acc_d;
                sum_q       <= sum_d;
                remaining_q <= remaining_d;
                valid_q     <= valid_d;
            end
        end

        assign bus.mult_fifo_read[g]            = mult_rd_s;
        assign bus.rowlen_fifo_read[g]          = rowlen_rd_s;
        assign bus.sum[g*acc_bits +: acc_bits]  = sum_q;
        assign bus.sum_valid[g]                 = valid_q;
    end

    row_accumulator_checker #(
        .channel_num (channel_num)
    ) u_checker (
        .clk               (clk),
        .rst               (rst),
        .mult_fifo_empty   (bus.mult_fifo_empty),
        .mult_fifo_read    (bus.mult_fifo_read),
        .rowlen_fifo_empty (bus.rowlen_fifo_empty),
        .rowlen_fifo_read  (bus.rowlen_fifo_read)
    );
endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: FWFT FIFO models per lane, a monitor
// recording pops and accepted sums, a vector table and corner-case sequences.
module tb_row_accumulator;
    localparam int CH = 4;
    localparam int VB = 16;
    localparam int LB = 16;
    localparam int AB = 40;
    localparam int PB = 2 * VB;

    typedef struct {
        int              lane;
        int              len;
        logic [3:0][PB-1:0] p;
        logic [AB-1:0]   exp_sum;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_accumulator_if #(.channel_num(CH), .val_bits(VB), .len_bits(LB), .acc_bits(AB)) bus ();

    row_accumulator #(.channel_num(CH), .val_bits(VB), .len_bits(LB), .acc_bits(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [PB-1:0] prod_mem [CH][64];
    logic [LB-1:0] rl_mem   [CH][64];
    int prod_wr [CH] = '{default: 0};
    int prod_rd [CH] = '{default: 0};
    int rl_wr   [CH] = '{default: 0};
    int rl_rd   [CH] = '{default: 0};
    logic [CH-1:0] stall = '0;
    logic [CH-1:0] ready = '0;

    for (genvar g = 0; g < CH; g++) begin : g_fifo
        assign bus.mult[g*PB +: PB]         = prod_mem[g][prod_rd[g][5:0]];
        assign bus.mult_fifo_empty[g]       = (prod_rd[g] == prod_wr[g]) || stall[g];
        assign bus.rowlen[g*LB +: LB]       = rl_mem[g][rl_rd[g][5:0]];
        assign bus.rowlen_fifo_empty[g]     = (rl_rd[g] == rl_wr[g]);
    end
    assign bus.sum_ready = ready;

    always @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (bus.mult_fifo_read[i] && (prod_rd[i] != prod_wr[i])) prod_rd[i] <= prod_rd[i] + 1;
            if (bus.rowlen_fifo_read[i] && (rl_rd[i] != rl_wr[i])) rl_rd[i] <= rl_rd[i] + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int m_pops [CH] = '{default: 0};
    int rl_pops [CH] = '{default: 0};
    int last_pop [CH] = '{default: 0};
    int rise [CH] = '{default: 0};
    int vcnt [CH] = '{default: 0};
    int got_cnt [CH] = '{default: 0};
    logic [AB-1:0] got_sum [CH][16];
    logic [CH-1:0] prev_v = '0;

    function automatic logic [AB-1:0] lane_sum(input int l);
        return bus.sum[l*AB +: AB];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: observes pops, read-while-empty, valid rise and accepted sums.
    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        for (int i = 0; i < CH; i++) begin
            if (bus.mult_fifo_read[i]) begin
                if (bus.mult_fifo_empty[i]) viol++;
                else begin m_pops[i]++; last_pop[i] = cyc; end
            end
            if (bus.rowlen_fifo_read[i]) begin
                if (bus.rowlen_fifo_empty[i]) viol++;
                else rl_pops[i]++;
            end
            if (bus.sum_valid[i]) begin
                vcnt[i]++;
                if (!prev_v[i]) rise[i] = cyc;
                if (ready[i]) begin
                    got_sum[i][got_cnt[i][3:0]] = lane_sum(i);
                    got_cnt[i]++;
                end
            end
            prev_v[i] = bus.sum_valid[i];
        end
    end

    task automatic push_prod(input int lane, input logic [PB-1:0] v);
        prod_mem[lane][prod_wr[lane][5:0]] = v;
        prod_wr[lane]++;
    endtask

    task automatic push_rowlen(input int lane, input int len);
        rl_mem[lane][rl_wr[lane][5:0]] = LB'(len);
        rl_wr[lane]++;
    endtask

    task automatic push_row(input vec_t v);
        for (int k = 0; k < v.len; k++) push_prod(v.lane, v.p[k]);
        push_rowlen(v.lane, v.len);
    endtask

    task automatic wait_got(input int lane, input int target, input int budget);
        int n = 0;
        while (got_cnt[lane] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_count_lane%0d", lane), 64'(got_cnt[lane]), 64'(target));
    endtask

    function automatic vec_t mk(input int lane, input int len, input logic [PB-1:0] a,
                                input logic [PB-1:0] b, input logic [PB-1:0] c,
                                input logic [PB-1:0] d, input logic [AB-1:0] e);
        vec_t v;
        v.lane = lane; v.len = len;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
        v.exp_sum = e;
        return v;
    endfunction

    vec_t vecs [6];

    initial begin
        int base, mp, rlp, n;
        int b0, b1, b2, b3;

        vecs[0] = mk(0, 3, 32'd5, 32'hFFFFFFFE, 32'd7, 32'd0, 40'd10);
        vecs[1] = mk(1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 40'd0);
        vecs[2] = mk(2, 2, 32'h3FFF0001, 32'h3FFF0001, 32'd0, 32'd0, 40'h007FFE0002);
        vecs[3] = mk(3, 1, 32'hFFFFFF9C, 32'd0, 32'd0, 32'd0, 40'hFFFFFFFF9C);
        vecs[4] = mk(0, 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 40'hFFFFFFFFFC);
        vecs[5] = mk(1, 2, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 40'hFF00000000);

        for (int i = 0; i < CH; i++)
            for (int k = 0; k < 64; k++) begin prod_mem[i][k] = '0; rl_mem[i][k] = '0; end

        // Reset with zero-length rows already waiting: nothing may be popped.
        for (int i = 0; i < CH; i++) push_rowlen(i, 0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_rowlen_read", 64'(bus.rowlen_fifo_read), 64'd0);
        check("reset_mult_read", 64'(bus.mult_fifo_read), 64'd0);
        check("reset_sum_valid", 64'(bus.sum_valid), 64'd0);
        check("reset_sum", 64'(bus.sum[63:0]) | 64'(bus.sum[159:64]), 64'd0);

        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("zero_row_valid_held", 64'(bus.sum_valid), 64'hF);
        check("zero_row_sum", 64'(bus.sum[63:0]) | 64'(bus.sum[159:64]), 64'd0);
        check("zero_row_no_mult_pop", 64'(m_pops[0] + m_pops[1] + m_pops[2] + m_pops[3]), 64'd0);
        check("zero_row_rowlen_pops", 64'(rl_pops[0] + rl_pops[1] + rl_pops[2] + rl_pops[3]), 64'd4);
        @(negedge clk);
        ready = 4'hF;
        for (int i = 0; i < CH; i++) begin
            wait_got(i, 1, 10);
            check($sformatf("zero_row_result_lane%0d", i), 64'(got_sum[i][0]), 64'd0);
        end

        // Table of single rows, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            int l, bg, bp, bv;
            l = vecs[v].lane;
            bg = got_cnt[l]; bp = m_pops[l]; bv = vcnt[l];
            @(negedge clk);
            push_row(vecs[v]);
            wait_got(l, bg + 1, 60);
            check($sformatf("vec%0d_sum", v), 64'(got_sum[l][bg[3:0]]), 64'(vecs[v].exp_sum));
            check($sformatf("vec%0d_pops", v), 64'(m_pops[l] - bp), 64'(vecs[v].len));
            check($sformatf("vec%0d_valid_cycles", v), 64'(vcnt[l] - bv), 64'd1);
            if (vecs[v].len > 0)
                check($sformatf("vec%0d_latency", v), 64'(rise[l] - last_pop[l]), 64'd1);
            #1;
            check($sformatf("vec%0d_valid_dropped", v), 64'(bus.sum_valid[l]), 64'd0);
        end

        // Backpressure: sum held, no pops of either FIFO until accepted.
        base = got_cnt[2];
        @(negedge clk);
        ready[2] = 1'b0;
        push_prod(2, 32'h3FFF0001); push_prod(2, 32'h3FFF0001); push_rowlen(2, 2);
        n = 0;
        while (!bus.sum_valid[2] && n < 20) begin @(negedge clk); n++; end
        check("hold_valid_seen", 64'(bus.sum_valid[2]), 64'd1);
        push_prod(2, 32'd3); push_rowlen(2, 1);
        mp = m_pops[2]; rlp = rl_pops[2];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold_sum_%0d", k), 64'(lane_sum(2)), 64'h007FFE0002);
            check($sformatf("hold_valid_%0d", k), 64'(bus.sum_valid[2]), 64'd1);
        end
        check("hold_no_mult_pop", 64'(m_pops[2]), 64'(mp));
        check("hold_no_rowlen_pop", 64'(rl_pops[2]), 64'(rlp));
        @(negedge clk);
        ready[2] = 1'b1;
        wait_got(2, base + 1, 10);
        check("hold_accepted_sum", 64'(got_sum[2][base[3:0]]), 64'h007FFE0002);
        wait_got(2, base + 2, 20);
        check("after_hold_sum", 64'(got_sum[2][base[3:0] + 4'd1]), 64'd3);

        // Product FIFO empty every other cycle.
        base = got_cnt[3]; mp = m_pops[3];
        @(negedge clk);
        push_prod(3, 32'd1); push_prod(3, 32'd2); push_prod(3, 32'd3); push_prod(3, 32'd4);
        push_rowlen(3, 4);
        n = 0;
        while (got_cnt[3] < base + 1 && n < 40) begin
            @(negedge clk);
            stall[3] = ~stall[3];
            n++;
        end
        stall[3] = 1'b0;
        check("toggle_accept", 64'(got_cnt[3]), 64'(base + 1));
        check("toggle_sum", 64'(got_sum[3][base[3:0]]), 64'd10);
        check("toggle_pops", 64'(m_pops[3] - mp), 64'd4);

        // All lanes at once, lane 2 output stalled.
        @(negedge clk);
        ready = 4'b1011;
        b0 = got_cnt[0]; b1 = got_cnt[1]; b2 = got_cnt[2]; b3 = got_cnt[3];
        push_prod(0, 32'd1); push_rowlen(0, 1);
        push_prod(1, 32'd2); push_prod(1, 32'd3); push_rowlen(1, 2);
        push_prod(2, 32'd4); push_prod(2, 32'd5); push_prod(2, 32'd6); push_rowlen(2, 3);
        push_prod(3, 32'd7); push_prod(3, 32'd8); push_prod(3, 32'd9); push_prod(3, 32'd10);
        push_rowlen(3, 4);
        wait_got(3, b3 + 1, 30);
        check("multi_lane0_sum", 64'(got_sum[0][b0[3:0]]), 64'd1);
        check("multi_lane1_sum", 64'(got_sum[1][b1[3:0]]), 64'd5);
        check("multi_lane3_sum", 64'(got_sum[3][b3[3:0]]), 64'd34);
        check("multi_rise_1_vs_0", 64'(rise[1] - rise[0]), 64'd1);
        check("multi_rise_2_vs_0", 64'(rise[2] - rise[0]), 64'd2);
        check("multi_rise_3_vs_0", 64'(rise[3] - rise[0]), 64'd3);
        check("multi_lane2_waiting", 64'(got_cnt[2]), 64'(b2));
        #1;
        check("multi_lane2_valid", 64'(bus.sum_valid[2]), 64'd1);
        @(negedge clk);
        ready[2] = 1'b1;
        wait_got(2, b2 + 1, 10);
        check("multi_lane2_sum", 64'(got_sum[2][b2[3:0]]), 64'd15);

        // Reset in the middle of a row discards it.
        base = got_cnt[0]; mp = m_pops[0];
        @(negedge clk);
        push_prod(0, 32'd5); push_prod(0, 32'd6); push_rowlen(0, 3);
        n = 0;
        while (m_pops[0] < mp + 2 && n < 20) begin @(negedge clk); n++; end
        check("abort_two_pops", 64'(m_pops[0]), 64'(mp + 2));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_valid_low", 64'(bus.sum_valid[0]), 64'd0);
        check("abort_sum_cleared", 64'(lane_sum(0)), 64'd0);
        push_prod(0, 32'd9); push_rowlen(0, 1);
        wait_got(0, base + 1, 30);
        check("abort_next_sum", 64'(got_sum[0][base[3:0]]), 64'd9);
        repeat (5) @(negedge clk);
        check("abort_single_result", 64'(got_cnt[0]), 64'(base + 1));

        check("read_while_empty", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
